load_use_scoreboard: RTL and testbench
======================================

LOAD_USE_SCOREBOARD -- requirements
Module: load_use_scoreboard

Interface
REQ-001 Parameter REG_W, default 5: register-specifier width. Register 0 is hardwired zero.
REQ-002 Parameter LOAD_LAT, default 1, legal range 1..4: number of advancing cycles a load's destination stays pending after it leaves decode.
REQ-003 Parameter CNT_W, default 16: stall_count width.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: id_valid  in  1  decode holds a live instruction.
REQ-007 Port: id_rs1, id_rs2  in  REG_W each  source register specifiers.
REQ-008 Port: id_rs1_used, id_rs2_used  in  1 each  the matching source is actually read.
REQ-009 Port: id_is_load  in  1  decode instruction is a load (lw/lh/lb/lbu/lhu).
REQ-010 Port: id_rd  in  REG_W  destination specifier.
REQ-011 Port: id_rd_wr  in  1  the instruction writes id_rd.
REQ-012 Port: flush  in  1  the decode instruction is squashed by a taken branch/jump.
REQ-013 Port: mem_ready  in  1  data memory is done; low freezes the pipeline.
REQ-014 Port: stall  out  1  hold PC and the IF/ID register this cycle.
REQ-015 Port: kill  out  1  inject a bubble into EX; force RegWr/MemWr/Branch low.
REQ-016 Port: busy  out  1  at least one pending load entry is valid.
REQ-017 Port: stall_count  out  CNT_W  count of bubbles inserted.

Function
REQ-018 Pending state is a LOAD_LAT-entry shift chain; each entry holds {valid, rd}.
REQ-019 src_hit is asserted when id_valid, used=1, rs!=0, and rs equals rd of any valid entry, for either source.
REQ-020 hazard = src_hit & ~flush.
REQ-021 stall = hazard | ~mem_ready (combinational).
REQ-022 kill = hazard & mem_ready (combinational); kill is never asserted while mem_ready=0.
REQ-023 Advance occurs on each edge with mem_ready=1:
  - entry[k] moves to entry[k+1];
  - entry[LOAD_LAT-1] retires;
  - entry[0] is loaded as described in REQ-024.
REQ-024 entry[0].valid = id_valid & id_is_load & id_rd_wr & (id_rd!=0) & ~hazard & ~flush; entry[0].rd = id_rd.
REQ-025 When mem_ready=0, all entries hold their values and no load is captured.
REQ-026 Flush does not clear entries, because loads already issued are older than the flushed instruction.
REQ-027 A load that is itself hazard-stalled is captured only in the cycle its hazard clears.
REQ-028 Duplicate rd values across entries are legal; a match is held until the last matching entry retires.
REQ-029 With LOAD_LAT=1, a dependent instruction decoded immediately after a load gets exactly one bubble.
REQ-030 With LOAD_LAT=N, a dependent instruction decoded immediately after a load gets exactly N bubbles.
REQ-031 busy = OR of all entry valid bits.

Reset
REQ-032 While reset=1 at an edge, all entry valid bits clear and stall_count returns to 0.
REQ-033 After reset: stall=~mem_ready, kill=0, busy=0.
REQ-034 Reset asserted mid-stall discards pending loads; the next cycle has no hazard.
REQ-035 Reset takes priority over advance and capture in the same cycle.

Configuration
REQ-036 Macro LOAD_USE_STALL_CNT_EN controls the stall counter.
REQ-037 When LOAD_USE_STALL_CNT_EN is defined, stall_count increments by 1 on every edge where kill=1 and saturates at 2^CNT_W-1.
REQ-038 When LOAD_USE_STALL_CNT_EN is undefined, the port remains present, stall_count is constant 0, and no counter flops exist.

Verification
REQ-039 LOAD_LAT=1:
  - stimulus: lw r5 decoded, then add r1,r5,r2;
  - response: stall=kill=1 for 1 cycle, then 0; busy=1 for 1 cycle.
REQ-040 LOAD_LAT=3:
  - stimulus: lw r7, then sw reading r7 (rs2_used=1);
  - response: kill=1 for exactly 3 cycles; stall_count 0 -> 3 with macro defined, stays 0 without it.
REQ-041 LOAD_LAT=1, three cases:
  - lw r0, then use of r0 -> no stall;
  - lw r4, then instruction with rs1=r4, rs1_used=0 -> no stall;
  - lw r4, then flush=1 with rs1=r4 -> stall=0 and nothing captured.
REQ-042 LOAD_LAT=2:
  - stimulus: lw r3, dependent instruction decoded, mem_ready=0 for 4 cycles;
  - response: stall=1 and kill=0 throughout, entries frozen; after mem_ready=1, kill=1 for the remaining 2 cycles.
REQ-043 LOAD_LAT=1:
  - stimulus: lw r2, then lw r6 reading r2, then use of r6;
  - response: first bubble; lw r6 captured after it; a second single bubble for the use of r6.
REQ-044 Reset during a load-use stall:
  - stimulus: reset=1 for 1 cycle, then the dependent instruction remains in decode;
  - response: kill=0, busy=0, stall_count=0.

Source files
------------

// File: rtl/load_use_scoreboard.sv
// Load-use hazard scoreboard: tracks in-flight load destinations and stalls dependent decodes.
// Optional bubble counter enabled by defining LOAD_USE_STALL_CNT_EN.
module load_use_scoreboard #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             id_is_load,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_wr,
    input  logic             flush,
    input  logic             mem_ready,
    output logic             stall,
    output logic             kill,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    logic [LOAD_LAT-1:0] vld_q, vld_d;
    logic [REG_W-1:0]    rd_q [LOAD_LAT];
    logic [REG_W-1:0]    rd_d [LOAD_LAT];

    logic rs1_hit, rs2_hit, src_hit, hazard, capture;

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (vld_q[k] && rd_q[k] == id_rs1) rs1_hit = 1'b1;
            if (vld_q[k] && rd_q[k] == id_rs2) rs2_hit = 1'b1;
        end
        // Register 0 never creates a dependency.
        src_hit = id_valid &&
                  ((id_rs1_used && id_rs1 != '0 && rs1_hit) ||
                   (id_rs2_used && id_rs2 != '0 && rs2_hit));
        hazard  = src_hit && !flush;
        stall   = hazard || !mem_ready;
        kill    = hazard && mem_ready;
        busy    = |vld_q;
        capture = id_valid && id_is_load && id_rd_wr && id_rd != '0 && !hazard && !flush;
    end

    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        if (mem_ready) begin
            for (int k = int'(LOAD_LAT) - 1; k > 0; k--) begin
                vld_d[k] = vld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            vld_d[0] = capture;
            rd_d[0]  = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
        rd_q <= rd_d;
    end

`ifdef LOAD_USE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (kill && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Self-checking bench for load_use_scoreboard: directed hazard scenarios plus random traffic
// compared against a pending-load list model.
module tb_load_use_scoreboard;

    localparam int unsigned RW  = 5;
    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 3;

    logic clk = 1'b0;
    logic reset;
    logic id_valid, id_rs1_used, id_rs2_used, id_is_load, id_rd_wr, flush, mem_ready;
    logic [RW-1:0] id_rs1, id_rs2, id_rd;
    logic stall, kill, busy;
    logic [CW-1:0] stall_count;

    always #5 clk = ~clk;

    load_use_scoreboard #(
        .REG_W(RW),
        .LOAD_LAT(LAT),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .id_rs1(id_rs1),
        .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_is_load(id_is_load),
        .id_rd(id_rd),
        .id_rd_wr(id_rd_wr),
        .flush(flush),
        .mem_ready(mem_ready),
        .stall(stall),
        .kill(kill),
        .busy(busy),
        .stall_count(stall_count)
    );

    // Model: list of in-flight loads, each with how many advancing edges it has seen.
    typedef struct {
        int rd;
        int age;
    } pend_t;
    pend_t pend[$];
    int cnt_m;
    int tests;
    int fails;
    logic obs_kill, obs_stall;

    function automatic bit pending(int r);
        foreach (pend[i]) if (pend[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic o, logic e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, o, e, $time);
        end
    endtask

    task automatic drive(bit v, int r1, bit u1, int r2, bit u2, bit ld, int rd, bit wr, bit fl,
                         bit mr);
        id_valid    = v;
        id_rs1      = RW'(r1);
        id_rs1_used = u1;
        id_rs2      = RW'(r2);
        id_rs2_used = u2;
        id_is_load  = ld;
        id_rd       = RW'(rd);
        id_rd_wr    = wr;
        flush       = fl;
        mem_ready   = mr;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Check outputs for the current inputs, then clock once and advance the model.
    task automatic cycle();
        bit hit, hz, cap;
        logic e_stall, e_kill, e_busy;
        logic [CW-1:0] e_cnt;
        @(negedge clk);
        hit = id_valid && ((id_rs1_used && id_rs1 != 0 && pending(int'(id_rs1))) ||
                           (id_rs2_used && id_rs2 != 0 && pending(int'(id_rs2))));
        hz      = hit && !flush;
        e_stall = hz || !mem_ready;
        e_kill  = hz && mem_ready;
        e_busy  = pend.size() != 0;
`ifdef LOAD_USE_STALL_CNT_EN
        e_cnt = CW'(cnt_m);
`else
        e_cnt = '0;
`endif
        chk("stall", stall, e_stall);
        chk("kill", kill, e_kill);
        chk("busy", busy, e_busy);
        tests++;
        assert (stall_count === e_cnt) else begin
            fails++;
            $error("FAIL stall_count: observed %0d expected %0d at %0t", stall_count, e_cnt,
                   $time);
        end
        obs_kill  = kill;
        obs_stall = stall;
        cap = id_valid && id_is_load && id_rd_wr && id_rd != 0 && !hz && !flush;
        @(posedge clk);
        if (reset) begin
            pend.delete();
            cnt_m = 0;
        end else if (mem_ready) begin
            for (int i = pend.size() - 1; i >= 0; i--) begin
                pend[i].age++;
                if (pend[i].age >= int'(LAT)) pend.delete(i);
            end
            if (cap) pend.push_back('{int'(id_rd), 0});
            if (e_kill && cnt_m < (1 << CW) - 1) cnt_m++;
        end
        #1;
    endtask

    // Hold a dependent instruction in decode until it stops stalling; returns bubbles seen.
    task automatic hold_dep(int r1, bit u1, int r2, bit u2, bit ld, int rd, output int nk);
        nk = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, r1, u1, r2, u2, ld, rd, ld, 0, 1);
            cycle();
            if (obs_kill) nk++;
            if (!obs_stall) return;
        end
        tests++;
        fails++;
        $error("FAIL hold_dep_timeout: still stalled after 12 cycles");
    endtask

    task automatic expect_n(string tag, int o, int e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    initial begin
        int nk;
        tests = 0;
        fails = 0;
        cnt_m = 0;
        reset = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, checked while reset is still held.
        cycle();
        chk("reset_stall", obs_stall, 1'b0);
        reset = 1'b0;

        // lw r7 then sw reading r7 through rs2: exactly LAT bubbles.
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 1);
        cycle();
        hold_dep(1, 1, 7, 1, 0, 0, nk);
        expect_n("lw_sw_bubbles", nk, int'(LAT));
        repeat (LAT) begin nop(); cycle(); end

        // lw r0 then use of r0: never a hazard.
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        cycle();
        hold_dep(0, 1, 0, 1, 0, 0, nk);
        expect_n("r0_bubbles", nk, 0);

        // lw r4 then rs1=r4 with rs1_used=0.
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 1);
        cycle();
        hold_dep(4, 0, 0, 0, 0, 0, nk);
        expect_n("unused_src_bubbles", nk, 0);
        repeat (LAT) begin nop(); cycle(); end

        // lw r4 then flushed reader of r4 which is itself a load: no stall, no capture.
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 1);
        cycle();
        drive(1, 4, 1, 0, 0, 1, 9, 1, 1, 1);
        cycle();
        chk("flush_stall", obs_stall, 1'b0);
        repeat (LAT + 1) begin nop(); cycle(); end
        chk("flush_no_capture_busy", busy, 1'b0);

        // lw r3, dependent held through 4 frozen cycles, then LAT bubbles still owed.
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 1);
        cycle();
        repeat (4) begin
            drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
            cycle();
            chk("freeze_stall", obs_stall, 1'b1);
            chk("freeze_kill", obs_kill, 1'b0);
        end
        hold_dep(3, 1, 0, 0, 0, 0, nk);
        expect_n("freeze_bubbles", nk, int'(LAT));

        // lw r2, lw r6 reading r2, then use of r6: LAT bubbles each.
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 1);
        cycle();
        hold_dep(2, 1, 0, 0, 1, 6, nk);
        expect_n("chain_first_bubbles", nk, int'(LAT));
        hold_dep(0, 0, 6, 1, 0, 0, nk);
        expect_n("chain_second_bubbles", nk, int'(LAT));

        // Reset mid-stall discards pending loads.
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 1);
        cycle();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        chk("post_reset_kill", obs_kill, 1'b0);
        chk("post_reset_busy", busy, 1'b0);

        // Random traffic on a small register range; counter saturates at 2^CW-1.
        for (int i = 0; i < 1500; i++) begin
            int ld;
            ld = ($urandom_range(0, 2) == 0) ? 1 : 0;
            drive(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 3), $urandom_range(0, 1), ld, $urandom_range(0, 3),
                  ($urandom_range(0, 5) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 4) != 0));
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
